// File: rtl/cache_seq_pkg.sv
// Shared types for the cache request sequencer.
//   state_t : sequencer FSM states
//   req_t   : default-width request entry {addr, wdata, we}
// Build option: ALIGN_CHECK_EN (see cache_req_sequencer.sv).
package cache_seq_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic                  we;
  } req_t;

endpackage

// File: rtl/seq_req_fifo.sv
// Synchronous request FIFO with no bypass.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push, wr_data   : write request and entry (ignored when full)
//   pop, rd_data    : read request and head entry (ignored when empty)
//   full, empty     : occupancy flags from registered count
//   count           : occupied entries, 0..DEPTH
// DEPTH must be a power of 2 and at least 2, so pointers wrap naturally.
module seq_req_fifo
  import cache_seq_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = req_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 wr_data,
  input  logic                   pop,
  output entry_t                 rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic   [PW-1:0] wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses a push even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cache_req_sequencer.sv
// Front-end for the direct-mapped cache: buffers load/store requests in a
// FIFO, issues them one at a time as a single-cycle access pulse, captures
// the cache's registered Data_Out/Hit_Miss and returns an in-order response.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   req_valid/req_ready/req_addr/req_wdata/req_we : request handshake
//   rsp_valid/rsp_ready/rsp_rdata/rsp_hit/rsp_err : response handshake
//   cache_access/cache_addr/cache_wdata/cache_we  : cache request side
//   cache_data_out/cache_hit_miss      : cache registered outputs
//   fifo_count                         : occupied FIFO entries
//   busy                               : FSM active or FIFO not empty
// Build option: define ALIGN_CHECK_EN to answer misaligned addresses with
// rsp_err=1 without touching the cache; otherwise rsp_err is tied 0.
module cache_req_sequencer
  import cache_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  input  logic                        req_we,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_hit,
  output logic                        rsp_err,
  output logic                        cache_access,
  output logic [ADDR_W-1:0]           cache_addr,
  output logic [DATA_W-1:0]           cache_wdata,
  output logic                        cache_we,
  input  logic [DATA_W-1:0]           cache_data_out,
  input  logic                        cache_hit_miss,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
  } entry_t;

  state_t state, state_nxt;
  entry_t in_entry, head, hold;
  logic   full, empty, pop, misaligned, take;

  assign in_entry = '{addr: req_addr, wdata: req_wdata, we: req_we};

  seq_req_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (req_valid),
    .wr_data (in_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign req_ready = !full;
  assign busy      = (state != IDLE) || !empty;

`ifdef ALIGN_CHECK_EN
  assign misaligned = (head.addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Head entry leaves the FIFO this cycle.
  assign take = (state == IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    cache_access = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          // Misaligned entries skip the cache and answer directly.
          state_nxt = misaligned ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        cache_access = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The hold register drives the cache bus, so the request stays stable
  // from ISSUE through WAIT and keeps its last value afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_hit   <= 1'b0;
    end else begin
      if (take && !misaligned) hold <= head;
      if (take && misaligned) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        rsp_hit   <= 1'b0;
      end
      // Cache outputs were registered at the ISSUE edge; capture them now.
      if (state == WAIT) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= cache_data_out;
        rsp_hit   <= cache_hit_miss;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

`ifdef ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)                  rsp_err <= 1'b0;
    else if (take)              rsp_err <= misaligned;
    else if (state == WAIT)     rsp_err <= 1'b0;
  end
`else
  assign rsp_err = 1'b0;
`endif

  assign cache_addr  = hold.addr;
  assign cache_wdata = hold.wdata;
  assign cache_we    = hold.we;

endmodule

// File: tb/tb_cache_req_sequencer.sv
// Bench for cache_req_sequencer: a behavioural 16-line direct-mapped cache
// (16-byte blocks, write-through, write-allocate) answers the DUT, and a
// flat memory/residency reference model predicts every response into a
// scoreboard queue that a negedge monitor drains.
module tb_cache_req_sequencer;

  localparam int FD = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr, cache_addr;
  logic [DW-1:0] req_wdata, rsp_rdata, cache_wdata, cache_data_out;
  logic          rsp_valid, rsp_ready, rsp_hit, rsp_err;
  logic          cache_access, cache_we, cache_hit_miss, busy;
  logic [$clog2(FD):0] fifo_count;

  always #5 clk = ~clk;

  cache_req_sequencer #(.FIFO_DEPTH(FD), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .cache_access(cache_access), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_we(cache_we),
    .cache_data_out(cache_data_out), .cache_hit_miss(cache_hit_miss),
    .fifo_count(fifo_count), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_init(input bit [29:0] w);
    return {2'b01, w} ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- cache environment ----------------
  logic [31:0] env_mem [bit [29:0]];
  logic [31:0] line_data [16][4];
  logic [23:0] line_tag [16];
  logic        line_vld [16];
  int          tot_acc = 0;
  int          tot_miss = 0;

  function automatic logic [31:0] env_rd(input bit [29:0] w);
    return env_mem.exists(w) ? env_mem[w] : mem_init(w);
  endfunction

  always @(posedge clk) begin
    int         ix, of;
    logic       h;
    bit  [29:0] base;
    if (reset) begin
      for (int i = 0; i < 16; i++) line_vld[i] = 1'b0;
      tot_acc = 0;
      tot_miss = 0;
      cache_data_out <= '0;
      cache_hit_miss <= 1'b0;
    end else if (cache_access) begin
      ix = int'(cache_addr[7:4]);
      of = int'(cache_addr[3:2]);
      h  = line_vld[ix] && (line_tag[ix] == cache_addr[31:8]);
      tot_acc++;
      if (!h) begin
        tot_miss++;
        base = {cache_addr[31:4], 2'b00};
        for (int j = 0; j < 4; j++) line_data[ix][j] = env_rd(base + 30'(j));
        line_tag[ix] = cache_addr[31:8];
        line_vld[ix] = 1'b1;
      end
      if (cache_we) begin
        line_data[ix][of] = cache_wdata;
        env_mem[cache_addr[31:2]] = cache_wdata;
        cache_data_out <= cache_wdata;
      end else begin
        cache_data_out <= line_data[ix][of];
      end
      cache_hit_miss <= h;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [bit [29:0]];
  int          ref_blk [int];   // cache index -> resident block number
  int          exp_acc = 0;

  task automatic ref_apply(input logic [31:0] a, input logic [31:0] d, input logic w);
    exp_t       e;
    bit  [29:0] wa;
    int         idx, blk;
`ifdef ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) begin
      e.rdata = '0; e.hit = 1'b0; e.err = 1'b1;
      exp_q.push_back(e);
      return;
    end
`endif
    wa  = a[31:2];
    idx = int'(a[7:4]);
    blk = int'(a[31:4]);
    e.hit = ref_blk.exists(idx) && (ref_blk[idx] == blk);
    ref_blk[idx] = blk;
    exp_acc++;
    if (w) begin
      ref_mem[wa] = d;
      e.rdata = d;
    end else begin
      e.rdata = ref_mem.exists(wa) ? ref_mem[wa] : mem_init(wa);
    end
    e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  logic        stall_prev = 1'b0;
  logic        acc_prev = 1'b0;
  logic [31:0] prev_rdata;
  logic        prev_hit, prev_err;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_prev = 1'b0;
      acc_prev   = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_hold_rdata", rsp_rdata, prev_rdata);
        chk("rsp_hold_hit_err", {30'd0, rsp_hit, rsp_err}, {30'd0, prev_hit, prev_err});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=%h required=none", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_hit", {31'd0, rsp_hit}, {31'd0, e.hit});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      prev_rdata = rsp_rdata;
      prev_hit   = rsp_hit;
      prev_err   = rsp_err;
      if (cache_access) chk("access_single_cycle", {31'd0, acc_prev}, 32'd0);
      acc_prev = cache_access;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w);
    int n = 0;
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_we = w;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout actual=req_ready0 required=req_ready1");
    end else begin
      ref_apply(a, d, w);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_scoreboard_empty", exp_q.size(), 32'd0);
    chk("drain_not_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    logic [31:0] a;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0;
    rsp_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_cache_access", {31'd0, cache_access}, 32'd0);
    chk("reset_cache_bus", cache_addr | cache_wdata | {31'd0, cache_we}, 32'd0);
    chk("reset_fifo_count", 32'(fifo_count), 32'd0);
    chk("reset_ready_busy", {30'd0, req_ready, busy}, 32'd2);
    reset = 1'b0;
    @(posedge clk); #1;

    // Cold load with latency check.
    send(32'h10, 32'h0, 1'b0);                 // accepted at E0
    @(posedge clk); #1;                        // E1: popped, ISSUE
    chk("lat_e1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat_e1_access", {31'd0, cache_access}, 32'd1);
    chk("lat_e1_addr", cache_addr, 32'h10);
    @(posedge clk); #1;                        // E2: WAIT
    chk("lat_e2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat_e2_access", {31'd0, cache_access}, 32'd0);
    chk("lat_e2_addr_stable", cache_addr, 32'h10);
    @(posedge clk); #1;                        // E3: response
    chk("lat_e3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    drain();
    chk("cold_accesses", 32'(tot_acc), 32'd1);

    // Repeat load hits.
    send(32'h10, 32'h0, 1'b0);
    drain();
    chk("warm_accesses", 32'(tot_acc), 32'd2);
    chk("warm_misses", 32'(tot_miss), 32'd1);

    // Store then load in the same block.
    send(32'h14, 32'hDEADBEEF, 1'b1);
    send(32'h14, 32'h0, 1'b0);
    drain();

    // Backpressure fills the FIFO.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(32'h100 + 32'(i * 4), $urandom, 1'($urandom_range(0, 1)));
    chk("bp_fifo_count", 32'(fifo_count), 32'd4);
    chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();

    // Randomized traffic with random response backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = {22'd0, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      send(a, $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Misaligned load.
    acc0 = tot_acc;
    send(32'h21, 32'h0, 1'b0);
    drain();
`ifdef ALIGN_CHECK_EN
    chk("misalign_no_access", 32'(tot_acc), 32'(acc0));
`else
    chk("misalign_access", 32'(tot_acc), 32'(acc0 + 1));
`endif
    chk("total_accesses", 32'(tot_acc), 32'(exp_acc));

    // Reset while the first request waits on the cache.
    send(32'h40, 32'h0, 1'b0);
    send(32'h80, 32'h0, 1'b0);
    send(32'hC0, 32'h0, 1'b0);
    chk("pre_reset_fifo_count", 32'(fifo_count), 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_reset_fifo_count", 32'(fifo_count), 32'd0);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    ref_blk.delete();
    exp_acc = 0;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_reset_no_access", 32'(tot_acc), 32'd0);
    send(32'h10, 32'h0, 1'b0);
    drain();
    chk("post_reset_misses", 32'(tot_miss), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
